// File: rtl/vfpu_engine.sv
// rtl/vfpu_engine.sv - elementwise FP32 join + 2-stage pipeline with full backpressure
// Optional NaN operand counter enabled by defining VFPU_ENGINE_NAN_CNT_EN.
module vfpu_engine #(
    parameter int LEN_WIDTH     = 16,
    parameter int NAN_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic [2:0]               op_i,
    input  logic [LEN_WIDTH-1:0]     len_i,
    input  logic                     a_valid_i,
    output logic                     a_ready_o,
    input  logic [31:0]              a_data_i,
    input  logic                     b_valid_i,
    output logic                     b_ready_o,
    input  logic [31:0]              b_data_i,
    output logic                     r_valid_o,
    input  logic                     r_ready_i,
    output logic [31:0]              r_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [NAN_CNT_WIDTH-1:0] nan_cnt_o
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [2:0]  OP_MIN    = 3'b000;
    localparam logic [2:0]  OP_MAX    = 3'b001;
    localparam logic [2:0]  OP_ABS    = 3'b010;
    localparam logic [2:0]  OP_NEG    = 3'b011;
    localparam logic [2:0]  OP_SGNJ   = 3'b100;
    localparam logic [2:0]  OP_CMPLT  = 3'b101;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [31:0] FP_ONE    = 32'h3F80_0000;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

    state_t               r_state;
    logic [2:0]           r_op;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_issue_cnt;
    logic [LEN_WIDTH-1:0] r_out_cnt;
    logic                 r_done;
    logic                 r_s1_valid;
    logic [31:0]          r_s1_a;
    logic [31:0]          r_s1_b;
    logic                 r_s2_valid;
    logic [31:0]          r_s2_data;

    logic                 w_s2_ready;
    logic                 w_s1_ready;
    logic                 w_issue_en;
    logic                 w_fire;
    logic                 w_out_hs;
    logic                 w_a_nan;
    logic                 w_b_nan;
    logic                 w_a_lt_b;
    logic [31:0]          w_result;

    function automatic logic f_is_nan(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    // Sign-magnitude ordering: any negative (including -0) is below any positive.
    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return a[31];
        else if (a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    assign w_s2_ready = !r_s2_valid || r_ready_i;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_issue_en = (r_state == S_RUN) && (r_issue_cnt < r_len) && w_s1_ready;
    assign a_ready_o  = w_issue_en && b_valid_i;
    assign b_ready_o  = w_issue_en && a_valid_i;
    assign w_fire     = w_issue_en && a_valid_i && b_valid_i;
    assign w_out_hs   = r_s2_valid && r_ready_i;

    assign w_a_nan    = f_is_nan(r_s1_a);
    assign w_b_nan    = f_is_nan(r_s1_b);
    assign w_a_lt_b   = f_lt(r_s1_a, r_s1_b);

    always_comb begin
        w_result = r_s1_a;
        case (r_op)
            OP_MIN, OP_MAX: begin
                if (w_a_nan && w_b_nan)
                    w_result = QNAN;
                else if (w_a_nan)
                    w_result = r_s1_b;
                else if (w_b_nan)
                    w_result = r_s1_a;
                else if (r_op == OP_MIN)
                    w_result = w_a_lt_b ? r_s1_a : r_s1_b;
                else
                    w_result = w_a_lt_b ? r_s1_b : r_s1_a;
            end
            OP_ABS:   w_result = {1'b0, r_s1_a[30:0]};
            OP_NEG:   w_result = {~r_s1_a[31], r_s1_a[30:0]};
            OP_SGNJ:  w_result = {r_s1_b[31], r_s1_a[30:0]};
            OP_CMPLT: w_result = (!w_a_nan && !w_b_nan && w_a_lt_b) ? FP_ONE : 32'h0;
            default:  w_result = r_s1_a;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state     <= S_IDLE;
            r_op        <= 3'b000;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_done      <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_a      <= 32'h0;
            r_s1_b      <= 32'h0;
            r_s2_valid  <= 1'b0;
            r_s2_data   <= 32'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_op        <= op_i;
                        r_len       <= len_i;
                        r_issue_cnt <= '0;
                        r_out_cnt   <= '0;
                        if (len_i == '0)
                            r_done <= 1'b1;
                        else
                            r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_fire)
                        r_issue_cnt <= r_issue_cnt + LEN_ONE;
                    if (w_out_hs) begin
                        r_out_cnt <= r_out_cnt + LEN_ONE;
                        if (r_out_cnt + LEN_ONE == r_len) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
            endcase

            // Stage 2 may drain and refill in the same cycle.
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid)
                    r_s2_data <= w_result;
            end
            if (w_s1_ready) begin
                r_s1_valid <= w_fire;
                if (w_fire) begin
                    r_s1_a <= a_data_i;
                    r_s1_b <= b_data_i;
                end
            end
        end
    end

    assign r_valid_o = r_s2_valid;
    assign r_data_o  = r_s2_data;
    assign busy_o    = (r_state == S_RUN);
    assign done_o    = r_done;

`ifdef VFPU_ENGINE_NAN_CNT_EN
    localparam logic [NAN_CNT_WIDTH-1:0] NAN_ONE = 1;
    logic [NAN_CNT_WIDTH-1:0] r_nan_cnt;
    logic                     w_op_uses_b;
    logic                     w_pair_nan;

    assign w_op_uses_b = (r_op == OP_MIN) || (r_op == OP_MAX) ||
                         (r_op == OP_SGNJ) || (r_op == OP_CMPLT);
    assign w_pair_nan  = f_is_nan(a_data_i) || (w_op_uses_b && f_is_nan(b_data_i));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_nan_cnt <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_nan_cnt <= '0;
        end else if (w_fire && w_pair_nan && (r_nan_cnt != '1)) begin
            r_nan_cnt <= r_nan_cnt + NAN_ONE;
        end
    end

    assign nan_cnt_o = r_nan_cnt;
`else
    assign nan_cnt_o = '0;
`endif

endmodule

// File: doc/vfpu_engine.md
Name: vfpu_engine

Overview:
- Elementwise FP32 compute stage of the vector FPU accelerator.
- Sits between the streamer's two load source streams (operands A, B) and its store sink stream (result R).
- Joins one A and one B element, applies the operation latched at job start through a 2-stage registered pipeline with full backpressure, and emits one result per pair.
- Processes exactly len elements per job and pulses done_o when the last result is accepted.

Parameters:
LEN_WIDTH, 16, width of job length and element counters
NAN_CNT_WIDTH, 16, width of NaN counter (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
clear_i  in  1  synchronous soft clear, same effect as rst_i
start_i  in  1  job start pulse, sampled in IDLE only
op_i  in  3  operation code, latched on start
len_i  in  LEN_WIDTH  element count, latched on start
a_valid_i  in  1  operand A valid
a_ready_o  out  1  operand A ready
a_data_i  in  32  operand A, FP32
b_valid_i  in  1  operand B valid
b_ready_o  out  1  operand B ready
b_data_i  in  32  operand B, FP32
r_valid_o  out  1  result valid
r_ready_i  in  1  result ready
r_data_o  out  32  result, FP32
busy_o  out  1  high while not IDLE
done_o  out  1  one-cycle pulse at job end
nan_cnt_o  out  NAN_CNT_WIDTH  NaN operand count (optional feature only)

Behaviour:
- Reset/clear: FSM to IDLE; all valids, counters, busy_o, done_o and r_data_o are 0. Both apply mid-job; in-flight data is discarded.
- FSM IDLE:
  - start_i=1 latches op_i/len_i and zeroes issue_cnt and out_cnt.
  - len_i!=0: go to RUN.
  - len_i==0: stay in IDLE and pulse done_o on the next cycle.
- FSM RUN: busy_o=1. start_i is ignored.
- Join:
  - issue_en = RUN & issue_cnt<len & s1_ready.
  - a_ready_o = issue_en & b_valid_i; b_ready_o = issue_en & a_valid_i.
  - A and B are always consumed together; readies never depend on own valid.
  - Fire: issue_cnt increments and stage 1 captures a, b.
- Pipeline:
  - s2_ready = !s2_valid | r_ready_i; s1_ready = !s1_valid | s2_ready.
  - Stage 1 registers operands. Stage 2 registers the computed result, which drives r_data_o.
  - Latency: 2 cycles from fire to r_valid_o with no stall.
  - Throughput: 1 element/cycle.
  - r_valid_o/r_data_o are held stable while r_valid_o & !r_ready_i.
- Completion:
  - out_cnt increments on each r_valid_o & r_ready_i.
  - When out_cnt reaches len: go to IDLE and pulse done_o in the following cycle, with busy_o=0 in that cycle.
  - Results beyond len are never produced.
- Operations (sign-magnitude compare, -0 < +0; NaN = exp all ones & mantissa!=0; canonical NaN 0x7FC00000):
  - 000 MIN: minNum. One NaN → other operand; both NaN → canonical.
  - 001 MAX: maxNum, with the same NaN rules as MIN.
  - 010 ABS: {0, a[30:0]}; b discarded.
  - 011 NEG: {~a[31], a[30:0]}; b discarded.
  - 100 SGNJ: {b[31], a[30:0]}.
  - 101 CMP_LT: 0x3F800000 if a<b, else 0x00000000; any NaN → 0x00000000.
  - 110/111: pass-through a.
- Simultaneous events:
  - Stage 2 drain and refill may occur in the same cycle.
  - A final output handshake in the same cycle as a stall is not a completion unless the handshake occurs.

Optional Feature:
- Macro VFPU_ENGINE_NAN_CNT_EN.
- Defined:
  - nan_cnt_o counts fired pairs where a or b is NaN (+1 per pair).
  - Saturates at all ones.
  - Cleared on start, rst_i and clear_i.
  - Ops ABS/NEG/pass-through check only a.
- Undefined: nan_cnt_o is tied to 0 and no counter logic is generated.

Test Plan:
- MIN, len=4, A={1.0,-0.0,NaN,NaN}, B={2.0,+0.0,3.0,NaN}, r_ready_i=1 → R={0x3F800000,0x80000000,0x40400000,0x7FC00000}; first r_valid_o 2 cycles after first fire; done_o 1 cycle after 4th handshake.
- CMP_LT, len=3, A={1.0,2.0,NaN}, B={2.0,1.0,0.0} → R={0x3F800000,0,0}.
- Backpressure: MAX, len=8, r_ready_i toggling 1/0, B valid delayed 3 cycles → exactly 8 results in order; r_data_o stable during stalls; no A consumed without B.
- len=0 start → done_o pulses the next cycle, busy_o stays 0, no readies asserted.
- rst_i asserted mid-job after 2 of 5 results, then new SGNJ job len=2, A=1.0, B=-5.0 → no residual output; R={0xBF800000,0xBF800000}.
- With VFPU_ENGINE_NAN_CNT_EN: MAX len=4, two pairs containing NaN → nan_cnt_o=2 at done_o; new start resets it to 0.
